// File: rtl/decode_stage.sv
// RV32I (+ optional RV32M) decode stage: decodes each accepted fetch beat in the
// same cycle and queues the decoded op in a DEPTH-entry FIFO that feeds execute.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 2,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INSTR,
  input  logic [XLEN-1:0] IN_PC,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [2:0]      OUT_CLASS,
  output logic [4:0]      OUT_ALU_OP,
  output logic [2:0]      OUT_FUNC3,
  output logic [4:0]      OUT_RS1,
  output logic [4:0]      OUT_RS2,
  output logic [4:0]      OUT_RD,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [XLEN-1:0] OUT_PC,
  output logic            OUT_ILLEGAL,
  output logic [15:0]     ILLEGAL_CNT
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_UPPER
  } class_e;

  typedef enum logic [4:0] {
    OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLL = 5'd2, OP_SLT = 5'd3, OP_SLTU = 5'd4,
    OP_XOR = 5'd5, OP_SRL = 5'd6, OP_SRA = 5'd7, OP_OR = 5'd8, OP_AND = 5'd9,
    OP_PASSB = 5'd10
  } alu_op_e;

  typedef struct packed {
    class_e          cls;
    alu_op_e         alu_op;
    logic [2:0]      func3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } dec_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [6:0]      w_opcode, w_funct7;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
  logic            w_legal, w_push, w_pop;
  dec_t            w_dec, w_head;

  assign w_opcode = INSTR[6:0];
  assign w_funct3 = INSTR[14:12];
  assign w_funct7 = INSTR[31:25];
  assign w_shamt  = XLEN'(INSTR[24:20]);
  assign w_imm_i  = sext({{20{INSTR[31]}}, INSTR[31:20]});
  assign w_imm_s  = sext({{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]});
  assign w_imm_b  = sext({{19{INSTR[31]}}, INSTR[31], INSTR[7], INSTR[30:25], INSTR[11:8], 1'b0});
  assign w_imm_u  = sext({INSTR[31:12], 12'b0});
  assign w_imm_j  = sext({{11{INSTR[31]}}, INSTR[31], INSTR[19:12], INSTR[20], INSTR[30:21], 1'b0});

  // NOTE: every signal gets a default at the top so no path through the case infers a latch.
  always_comb begin
    w_dec   = '0;
    w_legal = 1'b1;
    case (w_opcode)
      OPC_OP: begin
        w_dec.cls   = CLS_ALU_R;
        w_dec.func3 = w_funct3;
        w_dec.rs1   = INSTR[19:15];
        w_dec.rs2   = INSTR[24:20];
        w_dec.rd    = INSTR[11:7];
        if (w_funct7 == 7'b0000000)                        w_dec.alu_op = base_op(w_funct3);
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) w_dec.alu_op = OP_SUB;
        else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) w_dec.alu_op = OP_SRA;
        else if (ENABLE_M && w_funct7 == 7'b0000001)       w_dec.alu_op = alu_op_e'({2'b10, w_funct3});
        else                                               w_legal = 1'b0;
      end
      OPC_OP_IMM: begin
        w_dec.cls   = CLS_ALU_I;
        w_dec.func3 = w_funct3;
        w_dec.rs1   = INSTR[19:15];
        w_dec.rd    = INSTR[11:7];
        w_dec.imm   = w_imm_i;
        w_dec.alu_op = base_op(w_funct3);
        if (w_funct3 == 3'b001) begin
          w_dec.imm = w_shamt;
          w_legal   = (w_funct7 == 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          w_dec.imm    = w_shamt;
          w_dec.alu_op = w_funct7[5] ? OP_SRA : OP_SRL;
          w_legal      = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
        end
      end
      OPC_LOAD: begin
        w_dec = '{cls: CLS_LOAD, alu_op: OP_ADD, func3: w_funct3, rs1: INSTR[19:15],
                  rs2: 5'd0, rd: INSTR[11:7], imm: w_imm_i, pc: '0, illegal: 1'b0};
        w_legal = w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        w_dec = '{cls: CLS_STORE, alu_op: OP_ADD, func3: w_funct3, rs1: INSTR[19:15],
                  rs2: INSTR[24:20], rd: 5'd0, imm: w_imm_s, pc: '0, illegal: 1'b0};
        w_legal = w_funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_BRANCH: begin
        w_dec = '{cls: CLS_BRANCH, alu_op: OP_SUB, func3: w_funct3, rs1: INSTR[19:15],
                  rs2: INSTR[24:20], rd: 5'd0, imm: w_imm_b, pc: '0, illegal: 1'b0};
        w_legal = !(w_funct3 inside {3'b010, 3'b011});
      end
      OPC_JAL: begin
        w_dec = '{cls: CLS_JAL, alu_op: OP_ADD, func3: 3'd0, rs1: 5'd0,
                  rs2: 5'd0, rd: INSTR[11:7], imm: w_imm_j, pc: '0, illegal: 1'b0};
      end
      OPC_JALR: begin
        w_dec = '{cls: CLS_JALR, alu_op: OP_ADD, func3: w_funct3, rs1: INSTR[19:15],
                  rs2: 5'd0, rd: INSTR[11:7], imm: w_imm_i, pc: '0, illegal: 1'b0};
        w_legal = (w_funct3 == 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        w_dec.cls    = CLS_UPPER;
        w_dec.alu_op = (w_opcode == OPC_LUI) ? OP_PASSB : OP_ADD;
        w_dec.rd     = INSTR[11:7];
        w_dec.imm    = w_imm_u;
      end
      default: w_legal = 1'b0;
    endcase
    // Illegal entries carry only the PC so execute can raise the trap.
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.pc = IN_PC;
  end

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [15:0]   r_illegal_cnt;
  dec_t          r_mem [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign IN_READY  = (r_count < CW'(DEPTH));
  assign OUT_VALID = (r_count != '0);
  assign w_push    = IN_VALID && IN_READY && !FLUSH && !RSTN;
  assign w_pop     = OUT_VALID && OUT_READY;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_illegal_cnt <= '0;
    end else if (FLUSH) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_dec.illegal && r_illegal_cnt != 16'hFFFF)
          r_illegal_cnt <= r_illegal_cnt + 16'd1;
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // NOTE: queue storage is not reset; the head is masked to zero whenever the count is zero.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  assign w_head      = OUT_VALID ? r_mem[r_rd_ptr] : '0;
  assign OUT_CLASS   = w_head.cls;
  assign OUT_ALU_OP  = w_head.alu_op;
  assign OUT_FUNC3   = w_head.func3;
  assign OUT_RS1     = w_head.rs1;
  assign OUT_RS2     = w_head.rs2;
  assign OUT_RD      = w_head.rd;
  assign OUT_IMM     = w_head.imm;
  assign OUT_PC      = w_head.pc;
  assign OUT_ILLEGAL = w_head.illegal;
  assign ILLEGAL_CNT = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a plain RV32I reference decoder predicts each
// queued op; two instances (RV32M off / on) share the same stimulus.
module tb_decode_stage;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b1, FLUSH = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0;
  logic [31:0] INSTR = '0, IN_PC = '0;

  logic        in_ready [2], out_valid [2], o_ill [2];
  logic [2:0]  o_cls [2], o_f3 [2];
  logic [4:0]  o_alu [2], o_rs1 [2], o_rs2 [2], o_rd [2];
  logic [31:0] o_imm [2], o_pc [2];
  logic [15:0] icnt [2];
  exp_t        act [2];

  always #5 CLK = ~CLK;

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(1'b0)) dut (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(in_ready[0]),
    .INSTR(INSTR), .IN_PC(IN_PC), .OUT_VALID(out_valid[0]), .OUT_READY(OUT_READY),
    .OUT_CLASS(o_cls[0]), .OUT_ALU_OP(o_alu[0]), .OUT_FUNC3(o_f3[0]), .OUT_RS1(o_rs1[0]),
    .OUT_RS2(o_rs2[0]), .OUT_RD(o_rd[0]), .OUT_IMM(o_imm[0]), .OUT_PC(o_pc[0]),
    .OUT_ILLEGAL(o_ill[0]), .ILLEGAL_CNT(icnt[0]));

  decode_stage #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(1'b1)) dut_m (
    .CLK(CLK), .RSTN(RSTN), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(in_ready[1]),
    .INSTR(INSTR), .IN_PC(IN_PC), .OUT_VALID(out_valid[1]), .OUT_READY(OUT_READY),
    .OUT_CLASS(o_cls[1]), .OUT_ALU_OP(o_alu[1]), .OUT_FUNC3(o_f3[1]), .OUT_RS1(o_rs1[1]),
    .OUT_RS2(o_rs2[1]), .OUT_RD(o_rd[1]), .OUT_IMM(o_imm[1]), .OUT_PC(o_pc[1]),
    .OUT_ILLEGAL(o_ill[1]), .ILLEGAL_CNT(icnt[1]));

  assign act[0] = {o_cls[0], o_alu[0], o_f3[0], o_rs1[0], o_rs2[0], o_rd[0], o_imm[0], o_pc[0], o_ill[0]};
  assign act[1] = {o_cls[1], o_alu[1], o_f3[1], o_rs1[1], o_rs2[1], o_rd[1], o_imm[1], o_pc[1], o_ill[1]};

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference decoder: immediates built arithmetically from the field weights.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit en_m);
    int          base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int          f3 = int'(ins[14:12]);
    int          f7 = int'(ins[31:25]);
    int          s7 = $signed(ins[31:25]);
    int          imm_i = $signed(ins[31:20]);
    logic [31:0] imm_s = s7 * 32 + int'(ins[11:7]);
    logic [31:0] imm_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    logic [31:0] imm_u = int'(ins[31:12]) * 4096;
    logic [31:0] imm_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    bit          ok = 1'b1;
    exp_t        e = '0;
    case (ins[6:0])
      7'h33: begin
        e.cls = 0; e.f3 = 3'(f3); e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        if (f7 == 0)                    e.alu = 5'(base[f3]);
        else if (f7 == 32 && f3 == 0)   e.alu = 1;
        else if (f7 == 32 && f3 == 5)   e.alu = 7;
        else if (f7 == 1 && en_m)       e.alu = 5'(16 + f3);
        else                            ok = 1'b0;
      end
      7'h13: begin
        e.cls = 1; e.f3 = 3'(f3); e.rs1 = ins[19:15]; e.rd = ins[11:7];
        e.imm = imm_i; e.alu = 5'(base[f3]);
        if (f3 == 1) begin
          e.imm = int'(ins[24:20]); ok = (f7 == 0);
        end else if (f3 == 5) begin
          e.imm = int'(ins[24:20]); ok = (f7 == 0 || f7 == 32); e.alu = (f7 == 32) ? 7 : 6;
        end
      end
      7'h03: begin
        e.cls = 2; e.f3 = 3'(f3); e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.imm = imm_i;
        ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      end
      7'h23: begin
        e.cls = 3; e.f3 = 3'(f3); e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = imm_s;
        ok = (f3 <= 2);
      end
      7'h63: begin
        e.cls = 4; e.alu = 1; e.f3 = 3'(f3); e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.imm = imm_b;
        ok = (f3 != 2 && f3 != 3);
      end
      7'h6F: begin e.cls = 5; e.rd = ins[11:7]; e.imm = imm_j; end
      7'h67: begin
        e.cls = 6; e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.imm = imm_i; ok = (f3 == 0);
      end
      7'h37: begin e.cls = 7; e.alu = 10; e.rd = ins[11:7]; e.imm = imm_u; end
      7'h17: begin e.cls = 7; e.rd = ins[11:7]; e.imm = imm_u; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin e = '0; e.ill = 1'b1; end
    e.pc = pc;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    logic [6:0]  f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h7E};
    logic [31:0] ins = $urandom;
    int          k = $urandom_range(0, 10);
    if (k < 10) ins[6:0] = ops[k];
    if ($urandom_range(0, 3) != 0) ins[31:25] = f7s[$urandom_range(0, 3)];
    return ins;
  endfunction

  // Scoreboard: expected ops are queued when the upcoming edge will accept a beat,
  // and the head is compared against the DUT every cycle away from the edge.
  exp_t        q [2][$];
  logic [15:0] mcnt [2] = '{16'd0, 16'd0};
  bit          sb_on = 1'b0;

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      exp_t head;
      exp_t e;
      head = (q[d].size() != 0) ? q[d][0] : '0;
      if (sb_on) begin
        check($sformatf("dut%0d out_valid", d), out_valid[d], q[d].size() != 0);
        check($sformatf("dut%0d in_ready", d), in_ready[d], q[d].size() < DEPTH);
        check($sformatf("dut%0d illegal_cnt", d), icnt[d], mcnt[d]);
        check($sformatf("dut%0d head", d), act[d], head);
      end
      if (RSTN) begin
        q[d].delete();
        mcnt[d] = '0;
      end else if (FLUSH) begin
        q[d].delete();
      end else begin
        bit do_push;
        do_push = IN_VALID && (q[d].size() < DEPTH);
        if (q[d].size() != 0 && OUT_READY) void'(q[d].pop_front());
        if (do_push) begin
          e = ref_decode(INSTR, IN_PC, d == 1);
          q[d].push_back(e);
          if (e.ill && mcnt[d] != 16'hFFFF) mcnt[d]++;
        end
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rst);
    IN_VALID = v; INSTR = ins; IN_PC = pc; OUT_READY = ordy; FLUSH = fl; RSTN = rst;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    sb_on = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    check("reset out_valid", out_valid[0], 1'b0);
    check("reset in_ready", in_ready[0], 1'b1);
    check("reset payload", act[0], '0);

    step(1, 32'h002081B3, 32'h100, 0, 0, 0);
    check("add valid", out_valid[0], 1'b1);
    check("add fields", {o_cls[0], o_alu[0], o_rs1[0], o_rs2[0], o_rd[0]}, {3'd0, 5'd0, 5'd1, 5'd2, 5'd3});
    check("add imm", o_imm[0], 32'h0);
    check("add pc", o_pc[0], 32'h100);
    step(0, 0, 0, 1, 0, 0);

    step(1, 32'hFFF00093, 32'h104, 1, 0, 0);
    check("addi imm", o_imm[0], 32'hFFFFFFFF);
    check("addi class/op", {o_cls[0], o_alu[0]}, {3'd1, 5'd0});
    step(1, 32'h123452B7, 32'h108, 1, 0, 0);
    check("lui class/op", {o_cls[0], o_alu[0], o_rd[0]}, {3'd7, 5'd10, 5'd5});
    check("lui imm", o_imm[0], 32'h12345000);

    step(1, 32'h7E2081B3, 32'h10C, 1, 0, 0);
    check("bad funct7 illegal", o_ill[0], 1'b1);
    step(1, 32'h022081B3, 32'h110, 1, 0, 0);
    check("mul no-M illegal", o_ill[0], 1'b1);
    check("illegal payload", act[0], {90'd0, 1'b1} | ({59'd0, 32'h110} << 1));
    check("illegal count", icnt[0], 16'd2);
    check("mul with M op", {o_ill[1], o_alu[1]}, {1'b0, 5'd16});
    step(0, 0, 0, 1, 0, 0);

    step(1, 32'h002081B3, 32'h200, 0, 0, 0);
    step(1, 32'h002081B3, 32'h204, 0, 0, 0);
    check("full in_ready", in_ready[0], 1'b0);
    step(1, 32'h002081B3, 32'h208, 0, 0, 0);
    check("full hold head", o_pc[0], 32'h200);
    step(1, 32'h002081B3, 32'h208, 1, 0, 0);
    check("full pop no push in_ready", in_ready[0], 1'b1);
    check("full pop head", o_pc[0], 32'h204);
    step(1, 32'h002081B3, 32'h208, 1, 0, 0);
    check("third accepted", o_pc[0], 32'h208);
    step(0, 0, 0, 1, 0, 0);
    check("drained", out_valid[0], 1'b0);

    step(1, 32'h002081B3, 32'h300, 0, 0, 0);
    step(1, 32'h002081B3, 32'h304, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 32'h308, 0, 1, 0);
    check("flush valid", out_valid[0], 1'b0);
    check("flush in_ready", in_ready[0], 1'b1);
    step(1, 32'h002081B3, 32'h30C, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 32'h310, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    check("flushed beat dropped", out_valid[0], 1'b0);
    check("flush keeps count", icnt[0], 16'd2);

    step(1, 32'h002081B3, 32'h400, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 32'h404, 1, 1, 1);
    check("mid reset payload", act[0], '0);
    check("mid reset ready/valid", {in_ready[0], out_valid[0]}, 2'b10);
    check("mid reset count", icnt[0], 16'd0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0);

    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++)
      step(1, 32'hFFFFFFFF, 32'(i) << 2, 1, 0, 0);
    check("saturated count", icnt[0], 16'hFFFF);
    check("saturated count M", icnt[1], 16'hFFFF);

    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised RV32I decode stage; next generation of the single-entry pipeline decoder.
- Accepts raw instructions from fetch over a valid/ready handshake and fully decodes every RV32I base format (R, I, L, S, B, U, J, JALR), plus optional RV32M.
- Pushes decoded ops into an internal DEPTH-entry output queue feeding execute, with flush and an illegal-instruction counter.
- Sits between fetch and execute.

Parameters:
- XLEN, 32, datapath width; immediates are sign-extended to XLEN and PC is passed through at XLEN.
- DEPTH, 2, output queue entries (1..4).
- ENABLE_M, 0, when 1 decode funct7=0000001 R-type as RV32M; when 0 those encodings are illegal.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RSTN  in  1  synchronous, active-high reset (asserted = 1).
- FLUSH  in  1  drop all queued ops and the current input beat.
- IN_VALID  in  1  fetch presents INSTR/IN_PC.
- IN_READY  out  1  stage can accept this cycle.
- INSTR  in  32  raw instruction.
- IN_PC  in  XLEN  instruction address.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  execute consumes head.
- OUT_CLASS  out  3  0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 UPPER.
- OUT_ALU_OP  out  5  operation code (see Behaviour).
- OUT_FUNC3  out  3  raw funct3 (load/store width, branch condition).
- OUT_RS1, OUT_RS2, OUT_RD  out  5 each  register indices; unused fields = 0.
- OUT_IMM  out  XLEN  sign-extended immediate; 0 for R-type.
- OUT_PC  out  XLEN  pass-through PC.
- OUT_ILLEGAL  out  1  entry is an illegal encoding.
- ILLEGAL_CNT  out  16  saturating count of illegal instructions accepted.

Behaviour:
- Reset (RSTN=1 at posedge):
  - Queue count and pointers go to 0, ILLEGAL_CNT goes to 0.
  - OUT_VALID=0, IN_READY=1. All OUT_* payload outputs read 0.
  - Reset overrides FLUSH and any handshake in the same cycle.
- Handshake:
  - Accept when IN_VALID && IN_READY; pop when OUT_VALID && OUT_READY.
  - IN_READY = (count < DEPTH), derived only from registered count; no combinational path from OUT_READY.
  - Push and pop in the same cycle are both allowed whenever IN_READY=1, and count is unchanged.
  - When full, the input is not accepted even if a pop occurs that cycle.
- Latency: an accepted instruction is decoded combinationally and written to the queue at the same edge. It is visible on OUT_* the next cycle when the queue was empty. Order is strictly FIFO.
- Queue: circular buffer; read and write pointers wrap from DEPTH-1 to 0. OUT_* always reflect the head entry, and are zero when empty.
- FLUSH (RSTN=0): next cycle count=0 and OUT_VALID=0. The input beat in the flush cycle is not stored and not counted. ILLEGAL_CNT is retained.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - LOAD, STORE, JAL, JALR and AUIPC use ADD (address/link arithmetic). BRANCH uses SUB. LUI uses PASSB.
- Decode rules (full 7-bit opcode compare):
  - R-type: funct7 must be 0000000, or 0100000 only with funct3 000/101; 0000001 is legal only if ENABLE_M.
  - I-ALU: SLLI needs funct7=0000000. SRLI/SRAI need funct7 0000000/0100000. Shamt is OUT_IMM[4:0] with upper bits 0.
  - LOAD: funct3 must be in {000,001,010,100,101}.
  - STORE: funct3 must be in {000,001,010}.
  - BRANCH: funct3 must not be 010 or 011.
  - JALR: funct3 must be 000.
- Immediates:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All sign-extended from bit 31 to XLEN.
- Illegal encodings, including any unknown opcode:
  - Pushed as an entry with OUT_ILLEGAL=1, OUT_PC valid, all other payload fields 0.
  - ILLEGAL_CNT increments on acceptance and saturates at 16'hFFFF.

Test Plan:
- Reset, then ADD x3,x1,x2 (0x002081B3) at PC 0x100 -> next cycle OUT_VALID=1, CLASS=0, ALU_OP=0, RS1=1, RS2=2, RD=3, IMM=0, PC=0x100.
- ADDI x1,x0,-1 (0xFFF00093), then LUI x5,0x12345 (0x123452B7) -> IMM=0xFFFFFFFF, ALU_OP=0; then CLASS=7, ALU_OP=10, IMM=0x12345000.
- 0x7E2081B3 (bad funct7), and 0x022081B3 with ENABLE_M=0 -> both OUT_ILLEGAL=1, ILLEGAL_CNT=2. With ENABLE_M=1, 0x022081B3 -> ALU_OP=16, not illegal.
- DEPTH=2, OUT_READY=0, IN_VALID held with 3 instrs -> IN_READY=0 after 2 accepts. Raising OUT_READY drains in order, and the third is accepted only after count<2.
- Queue holding 2 entries, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, dropped instr never appears, ILLEGAL_CNT unchanged.
- Reset asserted mid-stream with FLUSH=1 and a pop pending -> next cycle all outputs 0, IN_READY=1, ILLEGAL_CNT=0.
